vadd_bram_engine: RTL
=====================

VADD_BRAM_ENGINE -- requirements
Module: vadd_bram_engine

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13, giving the BRAM word address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the BRAM word width.
REQ-003 The block SHALL have parameter RD_LAT, default 1, legal 1..2, giving the BRAM port B read latency in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit, a run request sampled in IDLE only.
REQ-007 The block SHALL have port len, input, 16 bits, the element count.
REQ-008 The block SHALL have ports a_base, b_base and c_base, input, ADDR_WIDTH each, the operand A, operand B and result base word addresses.
REQ-009 The block SHALL have port busy, output, 1 bit, high while a run is in progress.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The block SHALL have port ovf, output, 1 bit, a sticky signed-overflow flag for the current or last run.
REQ-012 The block SHALL have port comp_addr_b, output, ADDR_WIDTH, the port B address.
REQ-013 The block SHALL have port comp_din_b, output, DATA_WIDTH, the port B write data.
REQ-014 The block SHALL have port comp_dout_b, input, DATA_WIDTH, the port B read data.
REQ-015 The block SHALL have port comp_en_b, output, 1 bit, the port B enable.
REQ-016 The block SHALL have port comp_we_b, output, 1 bit, the port B write enable.

Function
REQ-017 The FSM SHALL have the states IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR_C and DONE.
REQ-018 In IDLE, start=1 SHALL latch len, a_base, b_base and c_base, clear idx and ovf, and go to RD_A; if len=0 it SHALL go to DONE instead.
REQ-019 RD_A (1 cycle) SHALL drive comp_addr_b=a_base+idx, comp_en_b=1 and comp_we_b=0.
REQ-020 WAIT_A SHALL last RD_LAT cycles, keep comp_en_b=0, and capture comp_dout_b into a_reg at the clock edge ending its last cycle.
REQ-021 RD_B and WAIT_B SHALL behave identically to RD_A and WAIT_A, using b_base and b_reg.
REQ-022 WR_C (1 cycle) SHALL drive comp_addr_b=c_base+idx, comp_din_b=(a_reg+b_reg) mod 2^DATA_WIDTH, comp_en_b=1 and comp_we_b=1.
REQ-023 In WR_C, the block SHALL set ovf if the operands have the same sign and the sum sign differs from them.
REQ-024 From WR_C, the FSM SHALL go to DONE if idx=len-1, else increment idx and go to RD_A.
REQ-025 DONE (1 cycle) SHALL assert done=1 and then return to IDLE.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 Each element SHALL take exactly 2*RD_LAT+3 cycles.
REQ-028 done SHALL be high in the cycle len*(2*RD_LAT+3)+1 after the start-sampling edge (cycle 1 when len=0).
REQ-029 Address sums SHALL wrap modulo 2^ADDR_WIDTH.
REQ-030 start SHALL be ignored while busy=1, and input changes during a run SHALL have no effect.
REQ-031 start=1 held through DONE SHALL begin a new run from IDLE on the following cycle.
REQ-032 Outside RD_A, RD_B and WR_C, the block SHALL drive comp_en_b=0, comp_we_b=0, comp_addr_b=0 and comp_din_b=0.
REQ-033 At most one port B access SHALL occur per cycle, and no write SHALL occur except in WR_C.

Reset
REQ-034 rst_n low SHALL immediately force IDLE and set busy, done, ovf, comp_en_b, comp_we_b, comp_addr_b, comp_din_b, idx, a_reg and b_reg to 0.
REQ-035 Reset asserted mid-run SHALL abort the run with no further port B activity and no done pulse.
REQ-036 After reset deassertion, the block SHALL accept start on the first clock edge.

Verification
REQ-037 The bench SHALL cover: RD_LAT=1, len=3, A=[1,2,3] at 0x000, B=[10,20,30] at 0x100, c_base=0x200 -> mem[0x200..0x202]=[11,22,33], done at cycle 16, ovf=0.
REQ-038 The bench SHALL cover: len=0 -> done at cycle 1, comp_en_b never high, busy high for exactly 1 cycle.
REQ-039 The bench SHALL cover: A=0x7FFFFFFF, B=1, len=1 -> C=0x80000000 and ovf=1; a following run with 1+1 -> C=2 and ovf=0.
REQ-040 The bench SHALL cover: a_base=0x1FFF, len=2 -> reads at 0x1FFF then 0x0000.
REQ-041 The bench SHALL cover: RD_LAT=2, len=2 -> done at cycle 15, with correct sums.
REQ-042 The bench SHALL cover: rst_n low during the second element's WAIT_B -> all outputs 0 immediately, the second result word unwritten, and a fresh start completes normally.

Source files
------------

// File: rtl/vadd_bram_engine_if.sv
// BRAM port B bundle shared by the vector-add engine (master) and its memory (slave).
interface vadd_bram_engine_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] comp_addr_b;
    logic [DATA_WIDTH-1:0] comp_din_b;
    logic [DATA_WIDTH-1:0] comp_dout_b;
    logic                  comp_en_b;
    logic                  comp_we_b;

    modport master (
        output comp_addr_b,
        output comp_din_b,
        output comp_en_b,
        output comp_we_b,
        input  comp_dout_b
    );

    modport slave (
        input  comp_addr_b,
        input  comp_din_b,
        input  comp_en_b,
        input  comp_we_b,
        output comp_dout_b
    );
endinterface

// File: rtl/vadd_bram_engine.sv
// Element-wise C = A + B over one BRAM port: read A, read B, write C per element,
// with a sticky signed-overflow flag for the run.
module vadd_bram_engine #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [15:0]           len,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] c_base,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    vadd_bram_engine_if.master    bram
);
    localparam int unsigned LEN_WIDTH  = 16;
    localparam int unsigned WCNT_WIDTH = 2;
    localparam logic [WCNT_WIDTH-1:0] WCNT_LAST = WCNT_WIDTH'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        WAIT_A,
        RD_B,
        WAIT_B,
        WR_C,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [WCNT_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic [ADDR_WIDTH-1:0]  a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0]  b_base_q, b_base_d;
    logic [ADDR_WIDTH-1:0]  c_base_q, c_base_d;
    logic [DATA_WIDTH-1:0]  a_reg_q, a_reg_d;
    logic [DATA_WIDTH-1:0]  b_reg_q, b_reg_d;
    logic                   ovf_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [DATA_WIDTH-1:0]  din_d;
    logic                   en_d;
    logic                   we_d;
    logic [DATA_WIDTH-1:0]  sum_c;
    logic                   ovf_hit_c;

    // Signed overflow of the sum currently being written
    assign sum_c     = a_reg_q + b_reg_q;
    assign ovf_hit_c = (a_reg_q[DATA_WIDTH-1] == b_reg_q[DATA_WIDTH-1]) &&
                       (sum_c[DATA_WIDTH-1] != a_reg_q[DATA_WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            idx_q            <= '0;
            len_q            <= '0;
            wcnt_q           <= '0;
            a_base_q         <= '0;
            b_base_q         <= '0;
            c_base_q         <= '0;
            a_reg_q          <= '0;
            b_reg_q          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            ovf              <= 1'b0;
            bram.comp_addr_b <= '0;
            bram.comp_din_b  <= '0;
            bram.comp_en_b   <= 1'b0;
            bram.comp_we_b   <= 1'b0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            len_q            <= len_d;
            wcnt_q           <= wcnt_d;
            a_base_q         <= a_base_d;
            b_base_q         <= b_base_d;
            c_base_q         <= c_base_d;
            a_reg_q          <= a_reg_d;
            b_reg_q          <= b_reg_d;
            busy             <= (state_d != IDLE);
            done             <= (state_d == DONE);
            ovf              <= ovf_d;
            bram.comp_addr_b <= addr_d;
            bram.comp_din_b  <= din_d;
            bram.comp_en_b   <= en_d;
            bram.comp_we_b   <= we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        a_base_d = a_base_q;
        b_base_d = b_base_q;
        c_base_d = c_base_q;
        a_reg_d  = a_reg_q;
        b_reg_d  = b_reg_q;
        ovf_d    = ovf;
        addr_d   = '0;
        din_d    = '0;
        en_d     = 1'b0;
        we_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len;
                    a_base_d = a_base;
                    b_base_d = b_base;
                    c_base_d = c_base;
                    idx_d    = '0;
                    ovf_d    = 1'b0;
                    state_d  = (len == '0) ? DONE : RD_A;
                end
            end
            RD_A: begin
                wcnt_d  = '0;
                state_d = WAIT_A;
            end
            WAIT_A: begin
                if (wcnt_q == WCNT_LAST) begin
                    a_reg_d = bram.comp_dout_b;
                    state_d = RD_B;
                end else begin
                    wcnt_d = wcnt_q + WCNT_WIDTH'(1);
                end
            end
            RD_B: begin
                wcnt_d  = '0;
                state_d = WAIT_B;
            end
            WAIT_B: begin
                if (wcnt_q == WCNT_LAST) begin
                    b_reg_d = bram.comp_dout_b;
                    state_d = WR_C;
                end else begin
                    wcnt_d = wcnt_q + WCNT_WIDTH'(1);
                end
            end
            WR_C: begin
                if (ovf_hit_c) begin
                    ovf_d = 1'b1;
                end
                if (idx_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + LEN_WIDTH'(1);
                    state_d = RD_A;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Port B outputs are registered, so they are decoded from the state being entered
        case (state_d)
            RD_A: begin
                addr_d = a_base_d + ADDR_WIDTH'(idx_d);
                en_d   = 1'b1;
            end
            RD_B: begin
                addr_d = b_base_d + ADDR_WIDTH'(idx_d);
                en_d   = 1'b1;
            end
            WR_C: begin
                addr_d = c_base_d + ADDR_WIDTH'(idx_d);
                din_d  = a_reg_d + b_reg_d;
                en_d   = 1'b1;
                we_d   = 1'b1;
            end
            default: begin
                en_d = 1'b0;
            end
        endcase
    end
endmodule
